// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared defaults and pointer sizing for the nbit FIFO
package fifo_pkg;

  localparam int FIFO_DEPTH = 8;
  localparam int FIFO_WIDTH = 32;

  // Address bits plus one wrap bit, so full and empty can be told apart.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// rtl/fifo_ptr.sv - wrap-extended FIFO pointer with binary rollover
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          inc,
  output logic [ptr_width(DEPTH)-1:0]   ptr,
  output logic [ptr_width(DEPTH)-2:0]   addr
);

  localparam int PW = ptr_width(DEPTH);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc) ptr_d = ptr_q + PW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr  = ptr_q;
  assign addr = ptr_q[PW-2:0];

endmodule

// File: rtl/fifo_nbit.sv
// rtl/fifo_nbit.sv - single-clock FIFO with chip select, registered read data and full/empty flags
module fifo_nbit
  import fifo_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int WIDTH = FIFO_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cs,
  input  logic             we,
  input  logic             re,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] dout_q;
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    raddr;
  logic             wr_en;
  logic             rd_en;

  // Flags come from pointer registers only, so strobes never reach them combinationally.
  assign empty = (wptr == rptr);
  assign full  = (waddr == raddr) && (wptr[PW-1] != rptr[PW-1]);

  assign wr_en = cs && we && !full;
  assign rd_en = cs && re && !empty;

  fifo_ptr #(.DEPTH(DEPTH)) u_wptr (
    .clk  (clk),
    .reset(reset),
    .inc  (wr_en),
    .ptr  (wptr),
    .addr (waddr)
  );

  fifo_ptr #(.DEPTH(DEPTH)) u_rptr (
    .clk  (clk),
    .reset(reset),
    .inc  (rd_en),
    .ptr  (rptr),
    .addr (raddr)
  );

  // Storage is deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[waddr] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     dout_q <= '0;
    else if (rd_en) dout_q <= mem_q[raddr];
  end

  assign dout = dout_q;

  logic [PW-1:0] occ;
  assign occ = wptr - rptr;

  a_flags_exclusive: assert property (@(posedge clk) disable iff (!reset) !(full && empty));
  a_occ_bounded:     assert property (@(posedge clk) disable iff (!reset) occ <= PW'(DEPTH));

endmodule

// File: tb/tb_fifo_nbit.sv
// tb/tb_fifo_nbit.sv - scoreboard bench for fifo_nbit against a queue reference model
module tb_fifo_nbit;

  localparam int DEPTH = 8;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             cs, we, re;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             full, empty;

  fifo_nbit #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk  (clk),
    .reset(reset),
    .cs   (cs),
    .we   (we),
    .re   (re),
    .din  (din),
    .dout (dout),
    .full (full),
    .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             f;
    logic             e;
  } exp_t;

  exp_t             exp_q[$];
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] m_dout;
  int               tests = 0;
  int               fails = 0;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every clocked cycle leaves one expected snapshot to compare on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("dout", dout, e.d);
      check("full", WIDTH'(full), WIDTH'(e.f));
      check("empty", WIDTH'(empty), WIDTH'(e.e));
    end
  end

  // One clocked transaction; called just after a falling edge.
  task automatic cycle(input logic c, input logic w, input logic r, input logic [WIDTH-1:0] d);
    logic wa, ra;
    cs = c; we = w; re = r; din = d;
    wa = c && w && (mq.size() < DEPTH);
    ra = c && r && (mq.size() > 0);
    @(posedge clk);
    if (ra) m_dout = mq.pop_front();
    if (wa) mq.push_back(d);
    exp_q.push_back('{m_dout, mq.size() == DEPTH, mq.size() == 0});
    @(negedge clk);
  endtask

  task automatic model_reset();
    mq.delete();
    m_dout = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; cs = 1'b0; we = 1'b0; re = 1'b0; din = '0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    check("rst_empty", WIDTH'(empty), 1);
    check("rst_full", WIDTH'(full), 0);
    check("rst_dout", dout, 0);

    for (int i = 1; i <= 8; i++) cycle(1, 1, 0, WIDTH'(i));
    cycle(1, 1, 0, 32'h9);
    for (int i = 0; i < 9; i++) cycle(1, 0, 1, '0);

    cycle(1, 1, 0, 32'hA5A5A5A5);
    cycle(1, 0, 1, '0);
    cycle(1, 1, 0, 32'h5A5A5A5A);
    cycle(1, 0, 1, '0);

    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 32'h100 + WIDTH'(i));
    for (int i = 0; i < 3; i++) cycle(1, 1, 1, 32'h200 + WIDTH'(i));
    for (int i = 0; i < 4; i++) cycle(1, 0, 1, '0);

    cycle(1, 1, 1, 32'hE0E0E0E0);
    cycle(1, 0, 1, '0);

    for (int i = 0; i < 8; i++) cycle(1, 1, 0, 32'h300 + WIDTH'(i));
    cycle(1, 1, 1, 32'hDEADBEEF);
    for (int i = 0; i < 8; i++) cycle(1, 0, 1, '0);

    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 32'h400 + WIDTH'(i));
    cycle(1, 0, 1, '0);
    for (int i = 0; i < 4; i++) cycle(0, i[0], ~i[0] | i[1], 32'hBAD0 + WIDTH'(i));
    cycle(0, 1, 1, 32'hBAD9);
    for (int i = 0; i < 3; i++) cycle(1, 0, 1, '0);

    for (int i = 0; i < 5; i++) cycle(1, 1, 0, 32'h500 + WIDTH'(i));
    cycle(1, 0, 1, '0);
    #1;
    reset = 1'b0;
    #1;
    model_reset();
    check("midrst_empty", WIDTH'(empty), 1);
    check("midrst_full", WIDTH'(full), 0);
    check("midrst_dout", dout, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      logic c, w, r;
      c = ($urandom_range(0, 7) != 0);
      w = ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 70 : 35));
      r = ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 35 : 70));
      cycle(c, w, r, $urandom);
    end
    while (mq.size() > 0) cycle(1, 0, 1, '0);
    cycle(1, 0, 1, '0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
